// File: rtl/booth_seq_ctrl.sv
// Sequencer for a radix-2 Booth multiplier: load, add/sub decision, arithmetic shift and iteration count.
// Moore strobes; done pulses one cycle after the last shift; start is accepted only in IDLE or DONE.
module booth_seq_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          q0,
    input  logic          q_m1,
    output logic          init_en,
    output logic          a_load_en,
    output logic          alu_sub,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EVAL,
        S_ADD,
        S_SUB,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        init_en   = 1'b0;
        a_load_en = 1'b0;
        alu_sub   = 1'b0;
        shift_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                init_en = 1'b1;
                busy    = 1'b1;
                count_d = COUNT_INIT;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                busy = 1'b1;
                case ({q0, q_m1})
                    2'b01:   state_d = S_ADD;
                    2'b10:   state_d = S_SUB;
                    default: state_d = S_SHIFT;
                endcase
            end
            S_ADD: begin
                a_load_en = 1'b1;
                busy      = 1'b1;
                state_d   = S_SHIFT;
            end
            S_SUB: begin
                a_load_en = 1'b1;
                alu_sub   = 1'b1;
                busy      = 1'b1;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                // Saturate at zero so a corrupted count can never wrap into a long run.
                if (count_q != '0) count_d = count_q - COUNT_ONE;
                if (count_q <= COUNT_ONE) state_d = S_DONE;
                else                      state_d = S_EVAL;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = start ? S_INIT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            count_d = '0;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: drives a behavioural Booth datapath from the strobes and checks
// strobe order, timing, count and product against an arithmetic reference.
module tb_booth_seq_ctrl;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst, start, abort, q0, q_m1;
    logic          init_en, a_load_en, alu_sub, shift_en, busy, done;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .q0       (q0),
        .q_m1     (q_m1),
        .init_en  (init_en),
        .a_load_en(a_load_en),
        .alu_sub  (alu_sub),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    always #5 clk = ~clk;

    // A carries one guard bit so that subtracting the most negative M cannot overflow.
    logic [W:0]   dp_a;
    logic [W-1:0] dp_q, dp_m, op_m, op_q;
    logic         dp_qm1;
    logic         use_dp;
    logic [1:0]   hold_bits;

    always @(posedge clk) begin
        if (init_en) begin
            dp_a   <= '0;
            dp_q   <= op_q;
            dp_qm1 <= 1'b0;
            dp_m   <= op_m;
        end else if (a_load_en) begin
            dp_a <= alu_sub ? dp_a - {dp_m[W-1], dp_m} : dp_a + {dp_m[W-1], dp_m};
        end else if (shift_en) begin
            dp_a   <= {dp_a[W], dp_a[W:1]};
            dp_q   <= {dp_a[0], dp_q[W-1:1]};
            dp_qm1 <= dp_q[0];
        end
    end

    logic [31:0] outs;
    assign outs = 32'({init_en, a_load_en, alu_sub, shift_en, busy, done, count});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        q0   = use_dp ? dp_q[0] : hold_bits[1];
        q_m1 = use_dp ? dp_qm1  : hold_bits[0];
    endtask

    // Events: 1 = add, 2 = subtract, 3 = shift. Cycle 1 is the INIT cycle.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                          input bit pre_started, input bit keep_start);
        int         exp_ev[$];
        int         got_ev[$];
        int         exp_done;
        int         shifts;
        int         p;
        int         n;
        bit         seen_done;
        logic       prev;
        logic [1:0] pr;

        op_m     = m;
        op_q     = q;
        exp_done = 2;
        prev     = 1'b0;
        for (int i = 0; i < W; i++) begin
            pr   = use_dp ? {q[i], prev} : hold_bits;
            prev = q[i];
            if (pr == 2'b01) begin
                exp_ev.push_back(1);
                exp_done += 3;
            end else if (pr == 2'b10) begin
                exp_ev.push_back(2);
                exp_done += 3;
            end else begin
                exp_done += 2;
            end
            exp_ev.push_back(3);
        end

        if (!pre_started) start = 1'b1;
        tick();
        cyc = 1;
        check("init_cycle", 32'({init_en, busy}), 32'h3);
        if (!keep_start) start = 1'b0;

        seen_done = 1'b0;
        shifts    = 0;
        for (int k = 0; k < 40 && !seen_done; k++) begin
            tick();
            check("strobe_legal",
                  32'(($countones({init_en, a_load_en, shift_en}) <= 1) && !init_en &&
                      (!alu_sub || a_load_en) && (busy == !done)), 32'h1);
            if (a_load_en) got_ev.push_back(alu_sub ? 2 : 1);
            if (shift_en) begin
                check("count_at_shift", 32'(count), 32'(W - shifts));
                shifts++;
                got_ev.push_back(3);
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_cycle", 32'(cyc), 32'(exp_done));
                check("done_count", 32'(count), 32'h0);
            end
        end
        check("done_seen", 32'(seen_done), 32'h1);
        check("event_total", 32'(got_ev.size()), 32'(exp_ev.size()));
        n = (got_ev.size() < exp_ev.size()) ? got_ev.size() : exp_ev.size();
        for (int i = 0; i < n; i++) check("event_kind", 32'(got_ev[i]), 32'(exp_ev[i]));
        if (use_dp) begin
            p = $signed(m) * $signed(q);
            check("product", 32'({dp_a[W-1:0], dp_q}), 32'(p[2*W-1:0]));
        end
    endtask

    initial begin
        int evals;
        bit late_done;

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        use_dp    = 1'b0;
        hold_bits = 2'b00;
        q0        = 1'b0;
        q_m1      = 1'b0;
        op_m      = '0;
        op_q      = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", outs, 32'h0);

        // Held decision bits: pure shifts, all adds, all subtracts.
        hold_bits = 2'b00;
        run_op('0, '0, 1'b0, 1'b0);
        tick();
        check("idle_after_done", outs, 32'h0);
        hold_bits = 2'b01;
        run_op('0, '0, 1'b0, 1'b0);
        tick();
        hold_bits = 2'b10;
        run_op('0, '0, 1'b0, 1'b0);
        tick();

        use_dp = 1'b1;
        run_op(8'hFD, 8'h07, 1'b0, 1'b0);
        check("product_fd_07", 32'({dp_a[W-1:0], dp_q}), 32'h0000FFEB);
        tick();
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        check("product_80_80", 32'({dp_a[W-1:0], dp_q}), 32'h00004000);
        tick();

        // Abort in the third EVAL cycle.
        use_dp    = 1'b0;
        hold_bits = 2'b00;
        start     = 1'b1;
        tick();
        start = 1'b0;
        evals = 0;
        for (int k = 0; k < 20 && evals < 3; k++) begin
            tick();
            if (busy && !init_en && !a_load_en && !shift_en) evals++;
        end
        check("abort_reach_eval3", 32'(evals), 32'h3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", outs, 32'h0);
        late_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done || busy) late_done = 1'b1;
        end
        check("abort_no_done", 32'(late_done), 32'h0);
        use_dp = 1'b1;
        run_op(8'h35, 8'hA6, 1'b0, 1'b0);
        tick();

        // Synchronous reset held two cycles while in ADD.
        use_dp    = 1'b0;
        hold_bits = 2'b01;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10 && !a_load_en; k++) tick();
        check("reach_add", 32'(a_load_en), 32'h1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_add", outs, 32'h0);
        use_dp = 1'b1;
        run_op(8'h7F, 8'h81, 1'b0, 1'b0);
        tick();

        // start held high: ignored while busy, re-accepted in DONE; then start+abort in DONE.
        start = 1'b1;
        run_op(8'h5A, 8'hC3, 1'b0, 1'b1);
        run_op(8'hE7, 8'h19, 1'b1, 1'b1);
        abort = 1'b1;
        tick();
        check("start_abort_in_done", outs, 32'h0);
        abort = 1'b0;
        start = 1'b0;
        tick();
        check("idle_after_abort", outs, 32'h0);

        for (int t = 0; t < 20; t++) begin
            run_op(W'($urandom), W'($urandom), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
